stf_lag16_autocorr: RTL and testbench

- Upstream stage of the coarse CFO estimator.
- Consumes baseband I/Q samples of the 802.11 short training field (STF) and forms the lag-16 delayed autocorrelation sum C = Σ x[n]·conj(x[n−LAG]) over a window of WIN products.
- Presents C once per start request; the downstream angle/scale stage converts it to a CFO estimate.

---
 rtl/coarse_cfo_pkg.sv | 23 ++
 rtl/stf_lag16_autocorr_if.sv | 27 ++
 rtl/cmult_conj.sv | 36 +++
 rtl/stf_lag16_autocorr.sv | 134 +++++++++++++
 tb/tb_stf_lag16_autocorr.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/coarse_cfo_pkg.sv
// Shared widths, FSM states and sample type for the coarse CFO estimator front end.
package coarse_cfo_pkg;

    localparam int unsigned IN_W   = 16;
    localparam int unsigned LAG    = 16;
    localparam int unsigned WIN    = 128;
    localparam int unsigned PROD_W = 2 * IN_W + 1;
    localparam int unsigned ACC_W  = PROD_W + $clog2(WIN);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    typedef struct packed {
        logic signed [IN_W-1:0] re;
        logic signed [IN_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/stf_lag16_autocorr_if.sv
// Sample stream, result handshake and control signals of the lag-16 autocorrelator.
interface stf_lag16_autocorr_if
    import coarse_cfo_pkg::*;
();

    logic                    start;
    logic                    busy;
    logic                    s_valid;
    logic                    s_ready;
    logic signed [IN_W-1:0]  s_re;
    logic signed [IN_W-1:0]  s_im;
    logic signed [ACC_W-1:0] corr_re;
    logic signed [ACC_W-1:0] corr_im;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output start, s_valid, s_re, s_im, out_ready,
        input  busy, s_ready, corr_re, corr_im, out_valid
    );

    modport slave (
        input  start, s_valid, s_re, s_im, out_ready,
        output busy, s_ready, corr_re, corr_im, out_valid
    );

endinterface

// File: rtl/cmult_conj.sv
// Registered x * conj(y) at full product precision, with a matching valid flag.
module cmult_conj
    import coarse_cfo_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  cplx_t                    x,
    input  cplx_t                    y,
    output logic                     out_valid,
    output logic signed [PROD_W-1:0] out_re,
    output logic signed [PROD_W-1:0] out_im
);

    logic signed [PROD_W-1:0] a, b, c, d;

    assign a = PROD_W'($signed(x.re));
    assign b = PROD_W'($signed(x.im));
    assign c = PROD_W'($signed(y.re));
    assign d = PROD_W'($signed(y.im));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_re <= a * c + b * d;
                out_im <= b * c - a * d;
            end
        end
    end

endmodule

// File: rtl/stf_lag16_autocorr.sv
// Lag-LAG delayed autocorrelation over WIN products of the STF; one result per start request.
module stf_lag16_autocorr
    import coarse_cfo_pkg::*;
(
    input logic                 ap_clk,
    input logic                 ap_rst,
    stf_lag16_autocorr_if.slave bus
);

    localparam int unsigned PTR_W = (LAG > 1) ? $clog2(LAG) : 1;
    localparam int unsigned CNT_W = $clog2(((LAG > WIN) ? LAG : WIN) + 1);

    state_t                   state_q;
    cplx_t                    dline [LAG];
    logic [PTR_W-1:0]         wptr_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     s_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic signed [ACC_W-1:0]  acc_re_q, acc_im_q;
    logic signed [ACC_W-1:0]  corr_re_q, corr_im_q;

    logic                     accept;
    cplx_t                    x_new;
    cplx_t                    x_old;
    logic                     p_valid;
    logic signed [PROD_W-1:0] p_re, p_im;

    assign accept = bus.s_valid & s_ready_q;
    assign x_new  = '{re: bus.s_re, im: bus.s_im};
    assign x_old  = dline[wptr_q];

    assign bus.s_ready   = s_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.corr_re   = corr_re_q;
    assign bus.corr_im   = corr_im_q;

    // Delay-line contents need no reset: every slot is written in FILL before it is read.
    always_ff @(posedge ap_clk) begin
        if (accept) begin
            dline[wptr_q] <= x_new;
        end
    end

    cmult_conj u_cmult (
        .clk       (ap_clk),
        .rst       (ap_rst),
        .in_valid  (accept && (state_q == ACCUM)),
        .x         (x_new),
        .y         (x_old),
        .out_valid (p_valid),
        .out_re    (p_re),
        .out_im    (p_im)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            cnt_q       <= '0;
            s_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            corr_re_q   <= '0;
            corr_im_q   <= '0;
        end else begin
            if (p_valid) begin
                acc_re_q <= acc_re_q + ACC_W'(p_re);
                acc_im_q <= acc_im_q + ACC_W'(p_im);
            end
            if (accept) begin
                wptr_q <= (wptr_q == PTR_W'(LAG - 1)) ? '0 : wptr_q + 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q   <= FILL;
                        cnt_q     <= '0;
                        wptr_q    <= '0;
                        acc_re_q  <= '0;
                        acc_im_q  <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                FILL: begin
                    if (accept) begin
                        if (cnt_q == CNT_W'(LAG - 1)) begin
                            state_q <= ACCUM;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (cnt_q == CNT_W'(WIN - 1)) begin
                            state_q   <= DRAIN;
                            cnt_q     <= '0;
                            s_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles: one for the multiplier register, one for the final add.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= HOLD;
                        corr_re_q   <= acc_re_q;
                        corr_im_q   <= acc_im_q;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stf_lag16_autocorr.sv
// Directed bench for stf_lag16_autocorr: expected results queued at start, checked by a monitor.
module tb_stf_lag16_autocorr;
    import coarse_cfo_pkg::*;

    typedef struct {
        logic signed [ACC_W-1:0] re;
        logic signed [ACC_W-1:0] im;
    } exp_t;

    logic clk = 1'b0;
    logic ap_rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_acc = 0;
    int   rise_cyc = 0;
    logic got = 1'b0;
    logic ov_prev = 1'b0;
    exp_t exp_q[$];

    stf_lag16_autocorr_if bus ();

    stf_lag16_autocorr dut (
        .ap_clk (clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic signed [63:0] act,
                         input logic signed [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    // Monitor: every rising out_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!ap_rst && bus.out_valid && !ov_prev) begin
            rise_cyc <= cyc;
            got      <= 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("corr_re", bus.corr_re, e.re);
                check("corr_im", bus.corr_im, e.im);
            end
        end
        ov_prev <= bus.out_valid;
    end

    function automatic logic [31:0] sample(input int mode, input int n);
        case (mode)
            0:       return {16'sd1000, 16'sd0};
            1:       return (n < 16) ? {16'sd1000, 16'sd0} : {16'sd0, 16'sd1000};
            default: return {16'h8000, 16'h8000};
        endcase
    endfunction

    task automatic do_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Offers nmax samples (optionally with random gaps); returns at posedge+1 after the last accept.
    task automatic feed(input int mode, input bit gaps, input int nmax);
        int n = 0;
        int guard = 0;
        while (n < nmax && guard < 4000) begin
            bus.s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            {bus.s_re, bus.s_im} = sample(mode, n);
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) begin
                n++;
                last_acc = cyc;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        bus.s_valid = 1'b1;
        check("accept count", n, nmax);
    endtask

    task automatic run(input int mode, input bit gaps, input bit hold_low,
                       input logic signed [ACC_W-1:0] ere, input logic signed [ACC_W-1:0] eim);
        int   extra = 0;
        int   guard = 0;
        exp_t e;
        got = 1'b0;
        bus.out_ready = !hold_low;
        @(negedge clk);
        check("idle s_ready", bus.s_ready, 0);
        check("idle busy", bus.busy, 0);
        @(posedge clk);
        #1;
        do_start();
        check("fill s_ready", bus.s_ready, 1);
        check("fill busy", bus.busy, 1);
        e.re = ere;
        e.im = eim;
        exp_q.push_back(e);
        feed(mode, gaps, 144);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) extra++;
        end
        check("drain/hold accepts", extra, 0);
        if (hold_low) begin
            for (int k = 0; k < 10; k++) begin
                @(posedge clk);
                #1;
                bus.start = (k == 4);
                @(negedge clk);
                check("hold out_valid", bus.out_valid, 1);
                check("hold corr_re", bus.corr_re, ere);
                check("hold corr_im", bus.corr_im, eim);
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        while (!got && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("result seen", got, 1);
        check("out_valid latency", rise_cyc - last_acc, 3);
        check("post-handshake out_valid", bus.out_valid, 0);
        check("post-handshake busy", bus.busy, 0);
        check("post-handshake s_ready", bus.s_ready, 0);
        check("retained corr_re", bus.corr_re, ere);
        bus.s_valid = 1'b0;
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_re      = '0;
        bus.s_im      = '0;
        bus.out_ready = 1'b1;
        #1;
        check("reset s_ready", bus.s_ready, 0);
        check("reset out_valid", bus.out_valid, 0);
        check("reset busy", bus.busy, 0);
        check("reset corr_re", bus.corr_re, 0);
        check("reset corr_im", bus.corr_im, 0);
        repeat (3) @(negedge clk);
        ap_rst = 1'b0;
        @(posedge clk);
        #1;

        run(0, 1'b0, 1'b0, 40'sd128000000, 40'sd0);
        run(1, 1'b0, 1'b0, 40'sd112000000, 40'sd16000000);
        run(2, 1'b0, 1'b0, 40'sd274877906944, 40'sd0);
        run(1, 1'b1, 1'b0, 40'sd112000000, 40'sd16000000);
        run(0, 1'b0, 1'b1, 40'sd128000000, 40'sd0);

        // Abort after 60 accepts; nothing may be emitted for that run.
        got = 1'b0;
        @(posedge clk);
        #1;
        do_start();
        feed(1, 1'b0, 60);
        ap_rst = 1'b1;
        #1;
        check("abort s_ready", bus.s_ready, 0);
        check("abort busy", bus.busy, 0);
        check("abort out_valid", bus.out_valid, 0);
        check("abort corr_re", bus.corr_re, 0);
        check("abort corr_im", bus.corr_im, 0);
        @(negedge clk);
        ap_rst = 1'b0;
        bus.s_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abort no result", got, 0);
        run(0, 1'b0, 1'b0, 40'sd128000000, 40'sd0);

        check("leftover expectations", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
